// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory unit.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned accesses are trapped).
package dmem_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   localparam int WORD_W     = 32;
   localparam int BYTE_OFF_W = 2;

   // Larger of two latencies; sizes the shared access counter.
   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dmem_ram.sv
// Synchronous single-port word RAM: a read or write is performed on the
// clock edge where en is high; read data appears after that edge and is
// held until the next read.
module dmem_ram
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH_WORDS];

   // NOTE: the array has no reset so it maps onto RAM macros; contents survive reset.
   // Single port: write or read the addressed word when enabled.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[idx] <= wdata;
         end else begin
            rdata <= mem[idx];
         end
      end
   end

endmodule

// File: rtl/dmem_unit.sv
// Multi-cycle data-memory unit behind the core's load/store port.
// Latches one request, stalls the core for the access latency, performs a
// single RAM access in the last busy cycle, then pulses done_o with flags.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned accesses are
// suppressed and reported on misalign_o; otherwise misalign_o is tied 0).
module dmem_unit
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int RD_LATENCY  = 2,
   parameter int WR_LATENCY  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [WORD_W-1:0] addr_i,
   input  logic [WORD_W-1:0] wdata_i,
   output logic [WORD_W-1:0] rdata_o,
   output logic              stall_o,
   output logic              done_o,
   output logic              oor_o,
   output logic              misalign_o
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CNT_W = $clog2(max2(RD_LATENCY, WR_LATENCY)) + 1;
   localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_LATENCY - 1);
   localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_LATENCY - 1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               we_q;
   logic [WORD_W-1:0]  addr_q;
   logic [WORD_W-1:0]  wdata_q;
   logic               rd_sel;      // DONE of a valid load: RAM output is the result
   logic [WORD_W-1:0]  rdata_hold;  // last load result, shown outside that window
   logic [WORD_W-1:0]  ram_rdata;
   logic               last_busy;
   logic               oor;
   logic               misalign;
   logic               access_ok;

   assign last_busy = (state == S_BUSY) && (cnt == '0);
   assign oor       = |addr_q[WORD_W-1:IDX_W+BYTE_OFF_W];

`ifdef DMEM_MISALIGN_TRAP_EN
   assign misalign  = |addr_q[BYTE_OFF_W-1:0];
`else
   // Byte offset is ignored: every access is a whole-word access.
   logic unused_byte_off;
   assign unused_byte_off = &{1'b0, addr_q[BYTE_OFF_W-1:0]};
   assign misalign        = 1'b0;
`endif

   assign access_ok = !oor && !misalign;

   // The core is held from the request cycle until the access completes.
   assign stall_o = (state == S_BUSY) || ((state == S_IDLE) && req_i);
   assign rdata_o = rd_sel ? ram_rdata : rdata_hold;

   dmem_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_ram (
      .clk   (clk),
      .en    (last_busy && access_ok),
      .we    (we_q),
      .idx   (addr_q[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W]),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   // Access FSM: latch request, count down the latency, report completion.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_sel     <= 1'b0;
         rdata_hold <= '0;
         done_o     <= 1'b0;
         oor_o      <= 1'b0;
         misalign_o <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_i) begin
                  we_q    <= we_i;
                  addr_q  <= addr_i;
                  wdata_q <= wdata_i;
                  cnt     <= we_i ? WR_CNT : RD_CNT;
                  state   <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (cnt == '0) begin
                  done_o     <= 1'b1;
                  oor_o      <= oor;
                  misalign_o <= misalign;
                  rd_sel     <= !we_q && access_ok;
                  // A suppressed load returns zero.
                  if (!we_q && !access_ok) begin
                     rdata_hold <= '0;
                  end
                  state <= S_DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_DONE: begin
               done_o     <= 1'b0;
               oor_o      <= 1'b0;
               misalign_o <= 1'b0;
               rd_sel     <= 1'b0;
               if (rd_sel) begin
                  rdata_hold <= ram_rdata;
               end
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_unit.sv
// Self-checking bench for dmem_unit: a table of load/store vectors driven
// through a scoreboard, plus hand sequences for reset-in-busy, back-to-back
// accesses and a request seen only in the DONE cycle.
module tb_dmem_unit;

   localparam int DEPTH = 1024;
   localparam int RD_LAT = 2;
   localparam int WR_LAT = 1;
`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        oor;
      logic        mis;
   } vec_t;

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        oor;
      logic        mis;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        req_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        stall_o;
   logic        done_o;
   logic        oor_o;
   logic        misalign_o;

   int   n_cmp;
   int   n_err;
   int   cyc;
   int   req_cyc;
   int   done_cyc;
   exp_t sb[$];
   vec_t vecs[15];

   dmem_unit #(
      .DEPTH_WORDS (DEPTH),
      .RD_LATENCY  (RD_LAT),
      .WR_LATENCY  (WR_LAT)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_i      (req_i),
      .we_i       (we_i),
      .addr_i     (addr_i),
      .wdata_i    (wdata_i),
      .rdata_o    (rdata_o),
      .stall_o    (stall_o),
      .done_o     (done_o),
      .oor_o      (oor_o),
      .misalign_o (misalign_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input logic oor, input logic mis);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.oor = oor; v.mis = mis;
      return v;
   endfunction

   // Completion monitor: every done_o pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (!reset && done_o) begin
         if (sb.size() == 0) begin
            check("done_without_request", 32'(sb.size()), 32'd1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, ".rdata"}, rdata_o, e.rdata);
            check({e.tag, ".oor"}, {31'b0, oor_o}, {31'b0, e.oor});
            check({e.tag, ".misalign"}, {31'b0, misalign_o}, {31'b0, e.mis});
            check({e.tag, ".stall_in_done"}, {31'b0, stall_o}, 32'd0);
         end
      end
   end

   // Issue one access in an IDLE cycle, then wait (bounded) for its done_o pulse.
   task automatic access(input string tag, input vec_t v);
      exp_t e;
      int   cycles;
      int   stalls;
      int   lat;
      bit   got;
      lat = v.we ? WR_LAT : RD_LAT;
      @(negedge clk);
      req_i   = 1'b1;
      we_i    = v.we;
      addr_i  = v.addr;
      wdata_i = v.wdata;
      req_cyc = cyc;
      e.tag = tag; e.rdata = v.rdata; e.oor = v.oor; e.mis = v.mis;
      sb.push_back(e);
      #1;
      stalls = stall_o ? 1 : 0;
      @(posedge clk);
      #1;
      // Request is latched; scramble the inputs to prove they are not re-sampled.
      req_i   = 1'b0;
      we_i    = 1'($urandom_range(0, 1));
      addr_i  = $urandom();
      wdata_i = $urandom();
      cycles  = 0;
      got     = 1'b0;
      repeat (20) begin
         @(negedge clk);
         cycles++;
         if (done_o) begin
            got = 1'b1;
            break;
         end
         if (stall_o) stalls++;
      end
      done_cyc = cyc;
      if (!got) check({tag, ".timeout"}, 32'(cycles), 32'(lat + 1));
      else      check({tag, ".latency"}, 32'(cycles), 32'(lat + 1));
      check({tag, ".stall_cycles"}, 32'(stalls), 32'(lat + 1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] b2b_rd;
      int          r1, d1;
      n_cmp = 0; n_err = 0; cyc = 0;
      req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
      reset = 1'b1;

      // Table: expected rdata on a store is the held result of the previous load.
      vecs[0]  = mk(1, 32'h10,       32'hDEADBEEF, 32'h0,        0, 0);
      vecs[1]  = mk(0, 32'h10,       32'h0,        32'hDEADBEEF, 0, 0);
      vecs[2]  = mk(1, 32'h0,        32'hA5A50000, 32'hDEADBEEF, 0, 0);
      vecs[3]  = mk(1, 32'h1000,     32'hFFFFFFFF, 32'hDEADBEEF, 1, 0);
      vecs[4]  = mk(0, 32'h0,        32'h0,        32'hA5A50000, 0, 0);
      vecs[5]  = mk(0, 32'h1000,     32'h0,        32'h0,        1, 0);
      vecs[6]  = mk(1, 32'h20,       32'hCAFE0008, 32'h0,        0, 0);
      vecs[7]  = mk(0, 32'h20,       32'h0,        32'hCAFE0008, 0, 0);
      vecs[8]  = mk(0, 32'hFFFFFFFC, 32'h0,        32'h0,        1, 0);
      vecs[9]  = mk(1, 32'hFFC,      32'h77,       32'h0,        0, 0);
      vecs[10] = mk(0, 32'hFFC,      32'h0,        32'h77,       0, 0);
      vecs[11] = mk(1, 32'h12,       32'h11112222, 32'h77,       0, MIS_EN);
      vecs[12] = mk(0, 32'h10,       32'h0,        MIS_EN ? 32'hDEADBEEF : 32'h11112222, 0, 0);
      vecs[13] = mk(0, 32'h13,       32'h0,        MIS_EN ? 32'h0 : 32'h11112222, 0, MIS_EN);
      vecs[14] = mk(0, 32'h1002,     32'h0,        32'h0,        1, MIS_EN);

      // Reset state.
      repeat (3) @(negedge clk);
      check("reset.stall", {31'b0, stall_o}, 32'd0);
      check("reset.done", {31'b0, done_o}, 32'd0);
      check("reset.oor", {31'b0, oor_o}, 32'd0);
      check("reset.misalign", {31'b0, misalign_o}, 32'd0);
      check("reset.rdata", rdata_o, 32'd0);
      reset = 1'b0;

      foreach (vecs[i]) access($sformatf("vec%0d", i), vecs[i]);

      // Reset during the (final) BUSY cycle of a store: no commit, no done_o.
      @(negedge clk);
      req_i = 1'b1; we_i = 1'b1; addr_i = 32'h20; wdata_i = 32'h1234;
      @(posedge clk);
      #1 req_i = 1'b0;
      #1 reset = 1'b1;
      #1;
      check("rst_busy.stall", {31'b0, stall_o}, 32'd0);
      check("rst_busy.done", {31'b0, done_o}, 32'd0);
      check("rst_busy.rdata", rdata_o, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_busy.idle_stall", {31'b0, stall_o}, 32'd0);
      access("rst_busy.readback", mk(0, 32'h20, 32'h0, 32'hCAFE0008, 0, 0));

      // Back-to-back lw then sw: requests RD_LAT+2 apart, completions WR_LAT+2 apart.
      b2b_rd = MIS_EN ? 32'hDEADBEEF : 32'h11112222;
      access("b2b.lw", mk(0, 32'h10, 32'h0, b2b_rd, 0, 0));
      r1 = req_cyc; d1 = done_cyc;
      access("b2b.sw", mk(1, 32'h14, 32'h55, b2b_rd, 0, 0));
      check("b2b.req_spacing", 32'(req_cyc - r1), 32'(RD_LAT + 2));
      check("b2b.done_spacing", 32'(done_cyc - d1), 32'(WR_LAT + 2));
      access("b2b.readback", mk(0, 32'h14, 32'h0, 32'h55, 0, 0));

      // A request visible only during DONE belongs to the retiring instruction.
      req_i = 1'b1; we_i = 1'b1; addr_i = 32'h10; wdata_i = 32'h0;
      @(posedge clk);
      #1 req_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("done_req.stall%0d", k), {31'b0, stall_o}, 32'd0);
      end
      access("done_req.readback", mk(0, 32'h10, 32'h0, b2b_rd, 0, 0));

      repeat (3) @(negedge clk);
      check("scoreboard_drain", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
